peripheral_spram_arbiter: RTL and testbench

PERIPHERAL_SPRAM_ARBITER -- requirements
Module: peripheral_spram_arbiter

---
 rtl/peripheral_spram_arbiter.sv | 175 +++++++++++++++++
 tb/tb_peripheral_spram_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_spram_arbiter.sv
// Two-master AHB-Lite arbiter in front of a single shared SPRAM slave.
// Grants are decided at slave-ready boundaries; losing requests wait in a one-deep hold buffer.
module peripheral_spram_arbiter #(
  parameter int PLEN = 8,
  parameter int XLEN = 32
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic            M0_HSEL,
  input  logic [PLEN-1:0] M0_HADDR,
  input  logic [XLEN-1:0] M0_HWDATA,
  input  logic            M0_HWRITE,
  input  logic [2:0]      M0_HSIZE,
  input  logic [1:0]      M0_HTRANS,
  input  logic            M0_HMASTLOCK,
  output logic [XLEN-1:0] M0_HRDATA,
  output logic            M0_HREADYOUT,
  output logic            M0_HRESP,
  input  logic            M1_HSEL,
  input  logic [PLEN-1:0] M1_HADDR,
  input  logic [XLEN-1:0] M1_HWDATA,
  input  logic            M1_HWRITE,
  input  logic [2:0]      M1_HSIZE,
  input  logic [1:0]      M1_HTRANS,
  input  logic            M1_HMASTLOCK,
  output logic [XLEN-1:0] M1_HRDATA,
  output logic            M1_HREADYOUT,
  output logic            M1_HRESP,
  output logic            S_HSEL,
  output logic [PLEN-1:0] S_HADDR,
  output logic [XLEN-1:0] S_HWDATA,
  output logic            S_HWRITE,
  output logic [2:0]      S_HSIZE,
  output logic [1:0]      S_HTRANS,
  output logic            S_HREADY,
  output logic [2:0]      S_HBURST,
  output logic [3:0]      S_HPROT,
  output logic            S_HMASTLOCK,
  input  logic [XLEN-1:0] S_HRDATA,
  input  logic            S_HREADYOUT,
  input  logic            S_HRESP
);

  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_M0 = 2'd1, OWN_M1 = 2'd2} own_t;

  typedef struct packed {
    logic [PLEN-1:0] addr;
    logic            write;
    logic [2:0]      size;
    logic [1:0]      trans;
    logic            lock;
  } xfer_t;

  own_t        down_r;
  own_t        aown_s;
  logic        last_r;   // 1'b1: M1 won the most recent tie
  logic        lock_r;
  logic [1:0]  hv_r;
  xfer_t [1:0] hold_r;
  xfer_t [1:0] in_s;
  xfer_t [1:0] req_x_s;
  xfer_t       fwd_s;
  logic [1:0]  sel_s;
  logic [1:0]  mready_s;
  logic [1:0]  nreq_s;
  logic [1:0]  ereq_s;
  logic        tie_s;

  function automatic own_t own_of(input int n);
    return (n == 0) ? OWN_M0 : OWN_M1;
  endfunction

  assign in_s[0] = {M0_HADDR, M0_HWRITE, M0_HSIZE, M0_HTRANS, M0_HMASTLOCK};
  assign in_s[1] = {M1_HADDR, M1_HWRITE, M1_HSIZE, M1_HTRANS, M1_HMASTLOCK};
  assign sel_s   = {M1_HSEL, M0_HSEL};

  // Per-master readiness, new/effective requests and the boundary grant decision.
  always_comb begin
    mready_s = 2'b11;
    nreq_s   = 2'b00;
    ereq_s   = 2'b00;
    req_x_s  = '0;
    aown_s   = OWN_NONE;
    tie_s    = 1'b0;
    for (int n = 0; n < 2; n++) begin
      if (down_r == own_of(n)) mready_s[n] = S_HREADYOUT;
      else if (hv_r[n])        mready_s[n] = 1'b0;
      else                     mready_s[n] = 1'b1;
      // A master may only present a new address while it sees itself ready.
      nreq_s[n] = HRESETn & sel_s[n] & in_s[n].trans[1] & mready_s[n] & ~hv_r[n];
      ereq_s[n] = hv_r[n] | nreq_s[n];
      if (hv_r[n]) req_x_s[n] = hold_r[n];
      else         req_x_s[n] = in_s[n];
    end
    if (S_HREADYOUT) begin
      if (lock_r && (down_r == OWN_M0) && ereq_s[0])      aown_s = OWN_M0;
      else if (lock_r && (down_r == OWN_M1) && ereq_s[1]) aown_s = OWN_M1;
      else if (ereq_s == 2'b11) begin
        tie_s  = 1'b1;
        aown_s = last_r ? OWN_M0 : OWN_M1;
      end
      else if (ereq_s[0]) aown_s = OWN_M0;
      else if (ereq_s[1]) aown_s = OWN_M1;
      else                aown_s = OWN_NONE;
    end else begin
      aown_s = OWN_NONE;
    end
    if (aown_s == OWN_M1) fwd_s = req_x_s[1];
    else                  fwd_s = req_x_s[0];
  end

  // Forwarded address phase toward the slave; idle whenever nothing is granted.
  always_comb begin
    if (aown_s != OWN_NONE) begin
      S_HSEL      = 1'b1;
      S_HADDR     = fwd_s.addr;
      S_HWRITE    = fwd_s.write;
      S_HSIZE     = fwd_s.size;
      S_HTRANS    = fwd_s.trans;
      S_HMASTLOCK = fwd_s.lock;
    end else begin
      S_HSEL      = 1'b0;
      S_HADDR     = '0;
      S_HWRITE    = 1'b0;
      S_HSIZE     = 3'b000;
      S_HTRANS    = 2'b00;
      S_HMASTLOCK = 1'b0;
    end
  end

  // Data-phase write data follows the data-phase owner.
  always_comb begin
    case (down_r)
      OWN_M0:  S_HWDATA = M0_HWDATA;
      OWN_M1:  S_HWDATA = M1_HWDATA;
      default: S_HWDATA = '0;
    endcase
  end

  assign S_HREADY     = S_HREADYOUT;
  assign S_HBURST     = 3'b000;
  assign S_HPROT      = 4'b0011;
  assign M0_HREADYOUT = mready_s[0];
  assign M1_HREADYOUT = mready_s[1];
  assign M0_HRDATA    = (down_r == OWN_M0) ? S_HRDATA : '0;
  assign M1_HRDATA    = (down_r == OWN_M1) ? S_HRDATA : '0;
  assign M0_HRESP     = (down_r == OWN_M0) ? S_HRESP : 1'b0;
  assign M1_HRESP     = (down_r == OWN_M1) ? S_HRESP : 1'b0;

  // Ownership, lock, round-robin pointer and hold-buffer state.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      down_r <= OWN_NONE;
      last_r <= 1'b1;
      lock_r <= 1'b0;
      hv_r   <= 2'b00;
      hold_r <= '0;
    end else begin
      if (S_HREADYOUT) begin
        down_r <= aown_s;
        lock_r <= (aown_s != OWN_NONE) & fwd_s.lock;
        if (tie_s) last_r <= (aown_s == OWN_M1);
      end
      for (int n = 0; n < 2; n++) begin
        if (aown_s == own_of(n)) begin
          hv_r[n] <= 1'b0;
        end else if (nreq_s[n]) begin
          hv_r[n]   <= 1'b1;
          hold_r[n] <= in_s[n];
        end
      end
    end
  end

endmodule

// File: tb/tb_peripheral_spram_arbiter.sv
// Directed bench for peripheral_spram_arbiter with a small SPRAM slave model.
module tb_peripheral_spram_arbiter;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        M0_HSEL, M1_HSEL;
  logic [7:0]  M0_HADDR, M1_HADDR;
  logic [31:0] M0_HWDATA, M1_HWDATA;
  logic        M0_HWRITE, M1_HWRITE;
  logic [2:0]  M0_HSIZE, M1_HSIZE;
  logic [1:0]  M0_HTRANS, M1_HTRANS;
  logic        M0_HMASTLOCK, M1_HMASTLOCK;
  logic [31:0] M0_HRDATA, M1_HRDATA;
  logic        M0_HREADYOUT, M1_HREADYOUT;
  logic        M0_HRESP, M1_HRESP;
  logic        S_HSEL, S_HWRITE, S_HREADY, S_HMASTLOCK;
  logic [7:0]  S_HADDR;
  logic [31:0] S_HWDATA, S_HRDATA;
  logic [2:0]  S_HSIZE, S_HBURST;
  logic [1:0]  S_HTRANS;
  logic [3:0]  S_HPROT;
  logic        S_HREADYOUT, S_HRESP;

  int tests = 0;
  int fails = 0;

  peripheral_spram_arbiter #(.PLEN(8), .XLEN(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HSEL(M0_HSEL), .M0_HADDR(M0_HADDR), .M0_HWDATA(M0_HWDATA), .M0_HWRITE(M0_HWRITE),
    .M0_HSIZE(M0_HSIZE), .M0_HTRANS(M0_HTRANS), .M0_HMASTLOCK(M0_HMASTLOCK),
    .M0_HRDATA(M0_HRDATA), .M0_HREADYOUT(M0_HREADYOUT), .M0_HRESP(M0_HRESP),
    .M1_HSEL(M1_HSEL), .M1_HADDR(M1_HADDR), .M1_HWDATA(M1_HWDATA), .M1_HWRITE(M1_HWRITE),
    .M1_HSIZE(M1_HSIZE), .M1_HTRANS(M1_HTRANS), .M1_HMASTLOCK(M1_HMASTLOCK),
    .M1_HRDATA(M1_HRDATA), .M1_HREADYOUT(M1_HREADYOUT), .M1_HRESP(M1_HRESP),
    .S_HSEL(S_HSEL), .S_HADDR(S_HADDR), .S_HWDATA(S_HWDATA), .S_HWRITE(S_HWRITE),
    .S_HSIZE(S_HSIZE), .S_HTRANS(S_HTRANS), .S_HREADY(S_HREADY), .S_HBURST(S_HBURST),
    .S_HPROT(S_HPROT), .S_HMASTLOCK(S_HMASTLOCK), .S_HRDATA(S_HRDATA),
    .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP)
  );

  always #5 HCLK = ~HCLK;

  // Minimal SPRAM slave: address captured on ready, data phase in the following cycle(s).
  logic [31:0] mem [256];
  logic        dp_v_r, dp_w_r;
  logic [7:0]  dp_a_r;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_v_r <= 1'b0;
      dp_w_r <= 1'b0;
      dp_a_r <= 8'h00;
    end else if (S_HREADY) begin
      dp_v_r <= S_HSEL & S_HTRANS[1];
      dp_w_r <= S_HWRITE;
      dp_a_r <= S_HADDR;
    end
  end

  always_ff @(posedge HCLK) begin
    if (dp_v_r && dp_w_r && S_HREADY) mem[dp_a_r] <= S_HWDATA;
  end

  assign S_HRDATA = (dp_v_r && !dp_w_r) ? mem[dp_a_r] : 32'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic m0(input logic sel, input logic [1:0] tr, input logic wr,
                    input logic [7:0] a, input logic lk);
    M0_HSEL = sel; M0_HTRANS = tr; M0_HWRITE = wr; M0_HADDR = a; M0_HMASTLOCK = lk;
  endtask

  task automatic m1(input logic sel, input logic [1:0] tr, input logic wr,
                    input logic [7:0] a, input logic lk);
    M1_HSEL = sel; M1_HTRANS = tr; M1_HWRITE = wr; M1_HADDR = a; M1_HMASTLOCK = lk;
  endtask

  initial begin
    HRESETn = 1'b0;
    S_HREADYOUT = 1'b1; S_HRESP = 1'b0;
    M0_HSIZE = 3'b010; M1_HSIZE = 3'b010;
    M0_HWDATA = 32'h0; M1_HWDATA = 32'h0;
    m0(1'b1, 2'b10, 1'b0, 8'h10, 1'b0);
    m1(1'b0, 2'b00, 1'b0, 8'h00, 1'b0);
    #3;
    // Reset values, even with a request present
    check_eq("rst_s_hsel", S_HSEL, 32'd0);
    check_eq("rst_s_htrans", S_HTRANS, 32'd0);
    check_eq("rst_m0_rdy", M0_HREADYOUT, 32'd1);
    check_eq("rst_m1_rdy", M1_HREADYOUT, 32'd1);
    check_eq("rst_m0_resp", M0_HRESP, 32'd0);
    check_eq("rst_m0_rdata", M0_HRDATA, 32'd0);
    check_eq("s_hprot", S_HPROT, 32'h3);
    check_eq("s_hburst", S_HBURST, 32'h0);
    m0(1'b0, 2'b00, 1'b0, 8'h00, 1'b0);
    tick(); HRESETn = 1'b1;

    // Single master write then read
    tick(); m0(1'b1, 2'b10, 1'b1, 8'h10, 1'b0); #1;
    check_eq("a_wr_hsel", S_HSEL, 32'd1);
    check_eq("a_wr_haddr", S_HADDR, 32'h10);
    check_eq("a_wr_hwrite", S_HWRITE, 32'd1);
    check_eq("a_wr_htrans", S_HTRANS, 32'h2);
    tick(); m0(1'b1, 2'b10, 1'b0, 8'h10, 1'b0); M0_HWDATA = 32'hDEADBEEF; #1;
    check_eq("a_hwdata", S_HWDATA, 32'hDEADBEEF);
    check_eq("a_rd_haddr", S_HADDR, 32'h10);
    check_eq("a_rd_hwrite", S_HWRITE, 32'd0);
    check_eq("a_rd_m0rdy", M0_HREADYOUT, 32'd1);
    tick(); m0(1'b0, 2'b00, 1'b0, 8'h00, 1'b0); #1;
    check_eq("a_rdata", M0_HRDATA, 32'hDEADBEEF);
    check_eq("a_rdata_rdy", M0_HREADYOUT, 32'd1);
    check_eq("a_m1_rdata", M1_HRDATA, 32'd0);
    check_eq("a_idle_hsel", S_HSEL, 32'd0);
    tick(); M0_HWDATA = 32'h0; #1;
    check_eq("a_hwdata_none", S_HWDATA, 32'd0);

    // Simultaneous requests: M0 wins first tie, M1 wins the next
    tick(); m0(1'b1, 2'b10, 1'b0, 8'h20, 1'b0); m1(1'b1, 2'b10, 1'b0, 8'h30, 1'b0); #1;
    check_eq("b_tie1_addr", S_HADDR, 32'h20);
    check_eq("b_tie1_m1rdy", M1_HREADYOUT, 32'd1);
    tick(); m0(1'b0, 2'b00, 1'b0, 8'h00, 1'b0); #1;
    check_eq("b_m1_stall", M1_HREADYOUT, 32'd0);
    check_eq("b_m1_fwd", S_HADDR, 32'h30);
    check_eq("b_m1_fwd_sel", S_HSEL, 32'd1);
    tick(); m0(1'b1, 2'b10, 1'b0, 8'h40, 1'b0); m1(1'b1, 2'b10, 1'b0, 8'h50, 1'b0); #1;
    check_eq("b_m1_rdy_again", M1_HREADYOUT, 32'd1);
    check_eq("b_tie2_addr", S_HADDR, 32'h50);
    tick(); m0(1'b0, 2'b00, 1'b0, 8'h00, 1'b0); m1(1'b0, 2'b00, 1'b0, 8'h00, 1'b0); #1;
    check_eq("b_m0_stall", M0_HREADYOUT, 32'd0);
    check_eq("b_m0_fwd", S_HADDR, 32'h40);
    tick(); #1;
    check_eq("b_m0_done", M0_HREADYOUT, 32'd1);
    tick();

    // M1 locked sequence of three writes holds off M0
    m1(1'b1, 2'b10, 1'b1, 8'h60, 1'b1); #1;
    check_eq("c_w1_addr", S_HADDR, 32'h60);
    check_eq("c_w1_lock", S_HMASTLOCK, 32'd1);
    tick(); m1(1'b1, 2'b11, 1'b1, 8'h64, 1'b1); m0(1'b1, 2'b10, 1'b0, 8'h70, 1'b0); #1;
    check_eq("c_w2_addr", S_HADDR, 32'h64);
    check_eq("c_w2_trans", S_HTRANS, 32'h3);
    tick(); m1(1'b1, 2'b11, 1'b1, 8'h68, 1'b1); #1;
    check_eq("c_w3_addr", S_HADDR, 32'h68);
    check_eq("c_m0_stall1", M0_HREADYOUT, 32'd0);
    tick(); m1(1'b0, 2'b00, 1'b0, 8'h00, 1'b0); m0(1'b0, 2'b00, 1'b0, 8'h00, 1'b0); #1;
    check_eq("c_m0_fwd", S_HADDR, 32'h70);
    check_eq("c_unlock", S_HMASTLOCK, 32'd0);
    check_eq("c_m0_stall2", M0_HREADYOUT, 32'd0);
    tick(); #1;
    check_eq("c_m0_done", M0_HREADYOUT, 32'd1);
    check_eq("c_m1_done", M1_HREADYOUT, 32'd1);

    // Two-cycle error response routed to M0 only
    tick(); m0(1'b1, 2'b10, 1'b0, 8'h10, 1'b0); #1;
    check_eq("d_fwd", S_HSEL, 32'd1);
    tick(); m0(1'b0, 2'b00, 1'b0, 8'h00, 1'b0); S_HREADYOUT = 1'b0; S_HRESP = 1'b1; #1;
    check_eq("d_resp1", M0_HRESP, 32'd1);
    check_eq("d_rdy1", M0_HREADYOUT, 32'd0);
    check_eq("d_m1_resp1", M1_HRESP, 32'd0);
    check_eq("d_m1_rdy1", M1_HREADYOUT, 32'd1);
    tick(); S_HREADYOUT = 1'b1; #1;
    check_eq("d_resp2", M0_HRESP, 32'd1);
    check_eq("d_rdy2", M0_HREADYOUT, 32'd1);
    check_eq("d_m1_resp2", M1_HRESP, 32'd0);
    tick(); S_HRESP = 1'b0;

    // Both arrive while slave busy: both buffered, tie resolved when ready
    S_HREADYOUT = 1'b0;
    m0(1'b1, 2'b10, 1'b0, 8'h80, 1'b0); m1(1'b1, 2'b10, 1'b0, 8'h84, 1'b0); #1;
    check_eq("e_busy_hsel", S_HSEL, 32'd0);
    tick(); #1;
    check_eq("e_m0_held", M0_HREADYOUT, 32'd0);
    check_eq("e_m1_held", M1_HREADYOUT, 32'd0);
    tick(); S_HREADYOUT = 1'b1; #1;
    check_eq("e_first", S_HADDR, 32'h80);
    tick(); m0(1'b0, 2'b00, 1'b0, 8'h00, 1'b0); m1(1'b0, 2'b00, 1'b0, 8'h00, 1'b0); #1;
    check_eq("e_second", S_HADDR, 32'h84);
    tick(); tick();

    // Reset while M1 holds a request
    S_HREADYOUT = 1'b0;
    m1(1'b1, 2'b10, 1'b0, 8'h90, 1'b0);
    tick(); #1;
    check_eq("f_m1_held", M1_HREADYOUT, 32'd0);
    HRESETn = 1'b0; #1;
    check_eq("f_rst_m1rdy", M1_HREADYOUT, 32'd1);
    check_eq("f_rst_hsel", S_HSEL, 32'd0);
    m1(1'b0, 2'b00, 1'b0, 8'h00, 1'b0);
    tick(); HRESETn = 1'b1; S_HREADYOUT = 1'b1; #1;
    check_eq("f_no_stale", S_HSEL, 32'd0);
    check_eq("f_m1_free", M1_HREADYOUT, 32'd1);
    tick(); m0(1'b1, 2'b10, 1'b0, 8'hA0, 1'b0); #1;
    check_eq("f_new_req", S_HADDR, 32'hA0);
    check_eq("f_new_sel", S_HSEL, 32'd1);
    tick(); m0(1'b0, 2'b00, 1'b0, 8'h00, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
